mem_stage_lsu: RTL

//  Parametrised MEM pipeline stage sitting between EXE and WB. Replaces the fixed 1-cycle MEM stage.
//  - Waits for a variable-latency data-RAM response (data_ok) before releasing a load.
//  - Holds returned data while WB is stalled.
//  - Aligns and extends byte/half/word loads, then selects the register-file write data.
//  - Drives a bypass bus with a load-pending flag so ID can stall on load-use hazards.

---
 rtl/mem_stage_lsu_if.sv | 50 +++++
 rtl/mem_stage_lsu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: EXE->MEM capture, data-RAM response, MEM->WB and bypass
// signals of the MEM stage, bundled for the stage's port list.
// slave  : the MEM stage's view (consumes EXE/RAM/WB inputs, drives WB/bypass).
// master : the surrounding pipeline's view.
interface mem_stage_lsu_if #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int RF_ADDR_W = 5
);
  // EXE -> MEM
  logic                 in_valid;
  logic                 mem_allow_in;
  logic [PC_W-1:0]      in_pc_plus_4;
  logic [DATA_W-1:0]    in_alu_res;
  logic [RF_ADDR_W-1:0] in_rf_waddr;
  logic                 in_rf_we;
  logic [1:0]           in_wsel;
  logic [1:0]           in_ld_size;
  logic                 in_ld_sign;
  // data RAM response
  logic                 data_ok;
  logic [DATA_W-1:0]    rdata;
  // MEM -> WB
  logic                 wb_allow_in;
  logic                 wb_valid;
  logic                 wb_rf_we;
  logic [RF_ADDR_W-1:0] wb_rf_waddr;
  logic [DATA_W-1:0]    wb_rf_wdata;
  // bypass bus towards ID
  logic                 by_valid;
  logic                 by_we;
  logic [RF_ADDR_W-1:0] by_waddr;
  logic [DATA_W-1:0]    by_wdata;
  logic                 by_ld_pend;
  logic                 mem_exc;

  modport slave (
    input  in_valid, in_pc_plus_4, in_alu_res, in_rf_waddr, in_rf_we,
           in_wsel, in_ld_size, in_ld_sign, data_ok, rdata, wb_allow_in,
    output mem_allow_in, wb_valid, wb_rf_we, wb_rf_waddr, wb_rf_wdata,
           by_valid, by_we, by_waddr, by_wdata, by_ld_pend, mem_exc
  );

  modport master (
    output in_valid, in_pc_plus_4, in_alu_res, in_rf_waddr, in_rf_we,
           in_wsel, in_ld_size, in_ld_sign, data_ok, rdata, wb_allow_in,
    input  mem_allow_in, wb_valid, wb_rf_we, wb_rf_waddr, wb_rf_wdata,
           by_valid, by_we, by_waddr, by_wdata, by_ld_pend, mem_exc
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage between EXE and WB.
// Holds one instruction, waits for a variable-latency data-RAM response on
// loads, keeps the returned word while WB stalls, aligns/extends the load and
// selects the register-file write data. A bypass bus with a load-pending flag
// lets ID stall on load-use hazards.
// Optional feature: define MEM_MISALIGN_EXC_EN to flag misaligned half/word
// loads on mem_exc (such loads suppress the RF write and never wait for data).
module mem_stage_lsu #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int RF_ADDR_W = 5
) (
  input logic            clk,
  input logic            reset,
  mem_stage_lsu_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'b00;  // no load outstanding
  localparam logic [1:0] ST_WAIT = 2'b01;  // load captured, data not yet returned
  localparam logic [1:0] ST_HAVE = 2'b10;  // load data held, waiting for WB

  localparam logic [1:0] WSEL_ALU  = 2'b00;
  localparam logic [1:0] WSEL_PC8  = 2'b01;
  localparam logic [1:0] WSEL_LOAD = 2'b10;
  localparam logic [1:0] WSEL_NONE = 2'b11;

  // Pick the addressed byte/half out of the RAM word and extend it.
  function automatic logic [DATA_W-1:0] extend_load(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        off,
    input logic [1:0]        size,
    input logic              sign
  );
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = sign ? {{(DATA_W-8){b[7]}}, b}  : {{(DATA_W-8){1'b0}}, b};
      2'b01:   r = sign ? {{(DATA_W-16){h[15]}}, h} : {{(DATA_W-16){1'b0}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

`ifdef MEM_MISALIGN_EXC_EN
  // Half needs 2-byte alignment; word (and size 11) needs 4-byte alignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic m;
    case (size)
      2'b00:   m = 1'b0;
      2'b01:   m = off[0];
      default: m = (off != 2'b00);
    endcase
    return m;
  endfunction
`endif

  // ---- EXE -> MEM stage register (p1) ----
  logic                 vld_p1;
  logic [PC_W-1:0]      pc_plus_4_p1;
  logic [DATA_W-1:0]    alu_res_p1;
  logic [RF_ADDR_W-1:0] rf_waddr_p1;
  logic                 rf_we_p1;
  logic [1:0]           wsel_p1;
  logic [1:0]           ld_size_p1;
  logic                 ld_sign_p1;
  logic                 exc_p1;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [DATA_W-1:0]    hold_data;

  logic                 in_exc;
  logic                 is_load_p1;
  logic                 ready_go;
  logic                 allow_in;
  logic                 capture;
  logic                 cap_load;
  logic                 leave;
  logic [DATA_W-1:0]    ld_src;
  logic [DATA_W-1:0]    ld_data;
  logic [PC_W-1:0]      pc_plus_8;
  logic [DATA_W-1:0]    wdata;
  logic                 rf_we_final;

`ifdef MEM_MISALIGN_EXC_EN
  assign in_exc = (bus.in_wsel == WSEL_LOAD) & misaligned(bus.in_ld_size, bus.in_alu_res[1:0]);
`else
  assign in_exc = 1'b0;
`endif

  // A misaligned load is released at once, without a RAM response.
  assign is_load_p1 = (wsel_p1 == WSEL_LOAD) & ~exc_p1;
  assign ready_go   = ~is_load_p1 | (state == ST_HAVE) | ((state == ST_WAIT) & bus.data_ok);
  assign allow_in   = ~vld_p1 | (ready_go & bus.wb_allow_in);
  assign capture    = bus.in_valid & allow_in;
  assign cap_load   = capture & (bus.in_wsel == WSEL_LOAD) & ~in_exc;
  assign leave      = vld_p1 & ready_go & bus.wb_allow_in;

  // Load tracking: a response that arrives while the instruction is leaving
  // must not park in HAVE, or a load captured that same cycle would see stale data.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cap_load) state_nxt = ST_WAIT;
      ST_WAIT: if (bus.data_ok) state_nxt = leave ? (cap_load ? ST_WAIT : ST_IDLE) : ST_HAVE;
      ST_HAVE: if (leave) state_nxt = cap_load ? ST_WAIT : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control state: stage valid and load tracker; reset abandons any load.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      state  <= ST_IDLE;
    end else begin
      if (allow_in) vld_p1 <= bus.in_valid;
      state <= state_nxt;
    end
  end

  // Data fields of the stage register: loaded only on capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      pc_plus_4_p1 <= bus.in_pc_plus_4;
      alu_res_p1   <= bus.in_alu_res;
      rf_waddr_p1  <= bus.in_rf_waddr;
      rf_we_p1     <= bus.in_rf_we;
      wsel_p1      <= bus.in_wsel;
      ld_size_p1   <= bus.in_ld_size;
      ld_sign_p1   <= bus.in_ld_sign;
      exc_p1       <= in_exc;
    end
  end

  // Keep the returned word so a stalled WB still gets it after rdata moves on.
  always_ff @(posedge clk) begin
    if ((state == ST_WAIT) & bus.data_ok) hold_data <= bus.rdata;
  end

  // ---- MEM -> WB result selection ----
  assign ld_src    = (state == ST_WAIT) ? bus.rdata : hold_data;
  assign ld_data   = extend_load(ld_src, alu_res_p1[1:0], ld_size_p1, ld_sign_p1);
  assign pc_plus_8 = pc_plus_4_p1 + PC_W'(4);

  // Register-file write data by source select.
  always_comb begin
    wdata = '0;
    case (wsel_p1)
      WSEL_ALU:  wdata = alu_res_p1;
      WSEL_PC8:  wdata = DATA_W'(pc_plus_8);
      WSEL_LOAD: wdata = ld_data;
      WSEL_NONE: wdata = '0;
      default:   wdata = '0;
    endcase
  end

  assign rf_we_final = rf_we_p1 & vld_p1 & (wsel_p1 != WSEL_NONE) & ~exc_p1;

  assign bus.mem_allow_in = allow_in;
  assign bus.wb_valid     = vld_p1 & ready_go;
  assign bus.wb_rf_we     = rf_we_final;
  assign bus.wb_rf_waddr  = rf_waddr_p1;
  assign bus.wb_rf_wdata  = wdata;
  assign bus.by_valid     = vld_p1;
  assign bus.by_we        = rf_we_final;
  assign bus.by_waddr     = rf_waddr_p1;
  assign bus.by_wdata     = wdata;
  assign bus.by_ld_pend   = vld_p1 & is_load_p1 & ~ready_go;

`ifdef MEM_MISALIGN_EXC_EN
  assign bus.mem_exc = vld_p1 & exc_p1;
`else
  assign bus.mem_exc = 1'b0;
`endif

endmodule
